cram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port CPU RAM (`cram`) between two requesters: requester 0 (CPU datapath) and requester 1 (debug/loader). It serializes the requesters' accesses onto one RAM port and drives the RAM's address, data, `we` and `oe` inputs. It accounts for the RAM's one-cycle registered read latency and returns read data with a one-cycle acknowledge pulse. It sits between the requesters and the `cram` instance in the CPU top level.

---
 rtl/cram_arbiter_if.sv | 39 +++
 rtl/cram_arbiter.sv | 121 ++++++++++++
 tb/tb_cram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cram_arbiter_if.sv
// Bundles the two requester ports and the RAM-side port of the cram arbiter.
// The slave modport is seen by the arbiter; master is the requester/RAM side.
interface cram_arbiter_if #(
    parameter int unsigned p_data_width    = 16,
    parameter int unsigned p_address_width = 10
);
    logic                       req_0;
    logic                       req_1;
    logic                       we_0;
    logic                       we_1;
    logic [p_address_width-1:0] address_0;
    logic [p_address_width-1:0] address_1;
    logic [p_data_width-1:0]    in_0;
    logic [p_data_width-1:0]    in_1;
    logic                       ack_0;
    logic                       ack_1;
    logic [p_data_width-1:0]    out_0;
    logic [p_data_width-1:0]    out_1;

    logic [p_address_width-1:0] ram_address;
    logic [p_data_width-1:0]    ram_in;
    logic                       ram_we;
    logic                       ram_oe;
    logic [p_data_width-1:0]    ram_out;

    modport slave (
        input  req_0, req_1, we_0, we_1, address_0, address_1, in_0, in_1,
        output ack_0, ack_1, out_0, out_1,
        output ram_address, ram_in, ram_we, ram_oe,
        input  ram_out
    );

    modport master (
        output req_0, req_1, we_0, we_1, address_0, address_1, in_0, in_1,
        input  ack_0, ack_1, out_0, out_1,
        input  ram_address, ram_in, ram_we, ram_oe,
        output ram_out
    );
endinterface

// File: rtl/cram_arbiter.sv
// Round-robin arbiter sharing the single-port CPU RAM between the CPU datapath
// (port 0) and the debug/loader (port 1); handles the RAM's 1-cycle read latency.
module cram_arbiter #(
    parameter int unsigned p_data_width    = 16,
    parameter int unsigned p_address_width = 10
) (
    input  logic          i_w_clk,
    input  logic          i_w_rst_n,
    cram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA,
        DONE
    } state_t;

    state_t                     state;
    logic                       last;
    logic                       winner;
    logic                       cmd_we;
    logic [p_address_width-1:0] cmd_address;
    logic [p_data_width-1:0]    cmd_in;
    logic                       ack_0;
    logic                       ack_1;
    logic [p_data_width-1:0]    out_0;
    logic [p_data_width-1:0]    out_1;
    logic                       ram_we_q;
    logic                       ram_oe_q;

    logic                       pending;
    logic                       grant_1;
    logic                       sel_we;
    logic [p_address_width-1:0] sel_address;
    logic [p_data_width-1:0]    sel_in;

    // Under contention the port that did not win last time gets the grant.
    always_comb begin
        pending     = bus.req_0 | bus.req_1;
        grant_1     = bus.req_1 & (~bus.req_0 | ~last);
        sel_we      = grant_1 ? bus.we_1      : bus.we_0;
        sel_address = grant_1 ? bus.address_1 : bus.address_0;
        sel_in      = grant_1 ? bus.in_1      : bus.in_0;
    end

    always_ff @(posedge i_w_clk) begin
        if (!i_w_rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            winner      <= 1'b0;
            cmd_we      <= 1'b0;
            cmd_address <= '0;
            cmd_in      <= '0;
            ack_0       <= 1'b0;
            ack_1       <= 1'b0;
            out_0       <= '0;
            out_1       <= '0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
        end else begin
            ack_0 <= 1'b0;
            ack_1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending) begin
                        winner      <= grant_1;
                        last        <= grant_1;
                        cmd_we      <= sel_we;
                        cmd_address <= sel_address;
                        cmd_in      <= sel_in;
                        ram_we_q    <= sel_we;
                        ram_oe_q    <= ~sel_we;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_we_q <= 1'b0;
                    if (cmd_we) begin
                        ram_oe_q <= 1'b0;
                        ack_0    <= ~winner;
                        ack_1    <= winner;
                        state    <= DONE;
                    end else begin
                        ram_oe_q <= 1'b1;
                        state    <= RDATA;
                    end
                end
                RDATA: begin
                    // RAM output register now holds the word addressed in ACCESS.
                    if (winner) begin
                        out_1 <= bus.ram_out;
                    end else begin
                        out_0 <= bus.ram_out;
                    end
                    ack_0    <= ~winner;
                    ack_1    <= winner;
                    ram_oe_q <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack_0       = ack_0;
    assign bus.ack_1       = ack_1;
    assign bus.out_0       = out_0;
    assign bus.out_1       = out_1;
    assign bus.ram_address = cmd_address;
    assign bus.ram_in      = cmd_in;
    // Reset low must block a RAM write even in the cycle it is first asserted.
    assign bus.ram_we      = ram_we_q & i_w_rst_n;
    assign bus.ram_oe      = ram_oe_q;

endmodule

// File: tb/tb_cram_arbiter.sv
// Scoreboard bench for cram_arbiter: two requester drivers, a behavioural RAM,
// and an ack monitor comparing against a transaction-level memory model.
module tb_cram_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            solo;
        int            gap;
    } op_t;

    typedef struct {
        logic          we;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cram_arbiter_if #(.p_data_width(DW), .p_address_width(AW)) bus ();

    cram_arbiter #(.p_data_width(DW), .p_address_width(AW)) dut (
        .i_w_clk  (clk),
        .i_w_rst_n(rst_n),
        .bus      (bus)
    );

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] ram     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] model_out [2];
    exp_t          exp_q0[$];
    exp_t          exp_q1[$];
    op_t           ops0[$];
    op_t           ops1[$];
    int            ack_log[$];

    function automatic logic [DW-1:0] init_val(input int unsigned a);
        if (a == 32'h3FF) return 16'h1234;
        if (a == 32'h020) return 16'h0000;
        return 16'((a * 32'h9E37) ^ 32'h5A5A);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Single-port RAM with registered read, as the cram instance behaves.
    initial begin
        for (int unsigned i = 0; i < 1024; i++) begin
            ram[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        bus.ram_out = '0;
        forever begin
            @(posedge clk);
            if (bus.ram_we) ram[bus.ram_address] <= bus.ram_in;
            if (bus.ram_oe) bus.ram_out <= ram[bus.ram_address];
        end
    end

    task automatic handle_ack(input int p);
        exp_t          e;
        int            sz;
        logic [DW-1:0] own;
        logic [DW-1:0] other;
        if (p == 0) begin
            sz = exp_q0.size(); own = bus.out_0; other = bus.out_1;
        end else begin
            sz = exp_q1.size(); own = bus.out_1; other = bus.out_0;
        end
        check($sformatf("ack%0d_expected", p), 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            if (p == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            if (!e.we) begin
                check($sformatf("rdata%0d", p), 32'(own), 32'(e.data));
                model_out[p] = e.data;
            end
        end
        check($sformatf("out%0d_hold", 1 - p), 32'(other), 32'(model_out[1-p]));
        ack_log.push_back(p);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.ack_0 || bus.ack_1)) begin
            check("ack_onehot", 32'(bus.ack_0 & bus.ack_1), 32'd0);
            if (bus.ack_0) handle_ack(0);
            if (bus.ack_1) handle_ack(1);
        end
    end

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.req_0 = req; bus.we_0 = we; bus.address_0 = a; bus.in_0 = d;
        end else begin
            bus.req_1 = req; bus.we_1 = we; bus.address_1 = a; bus.in_1 = d;
        end
    endtask

    // Must be entered just after a rising edge; consumes that port's op queue.
    task automatic run_port(input int p);
        op_t  op;
        exp_t e;
        int   waited;
        int   we_cycles;
        bit   got;
        while ((p == 0 ? ops0.size() : ops1.size()) > 0) begin
            if (p == 0) op = ops0.pop_front();
            else        op = ops1.pop_front();
            if (op.gap > 0) begin
                set_port(p, 1'b0, op.we, op.addr, op.data);
                repeat (op.gap) @(posedge clk);
                #1;
            end
            e.we   = op.we;
            e.data = op.we ? op.data : ref_mem[op.addr];
            if (op.we) ref_mem[op.addr] = op.data;
            if (p == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            set_port(p, 1'b1, op.we, op.addr, op.data);
            waited = 0; we_cycles = 0; got = 0;
            while (!got && waited < 40) begin
                @(negedge clk);
                waited++;
                if (bus.ram_we) we_cycles++;
                got = (p == 0) ? bus.ack_0 : bus.ack_1;
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL port%0d_timeout: actual=no ack after %0d cycles required=ack", p, waited);
            end else if (op.solo) begin
                check($sformatf("latency%0d", p), 32'(waited), op.we ? 32'd3 : 32'd4);
                check($sformatf("we_pulse%0d", p), 32'(we_cycles), op.we ? 32'd1 : 32'd0);
            end
            @(posedge clk);
            #1;
        end
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic op_t mk(input logic we, input int unsigned a, input logic [DW-1:0] d,
                               input bit solo, input int gap);
        op_t o;
        o.we = we; o.addr = AW'(a); o.data = d; o.solo = solo; o.gap = gap;
        return o;
    endfunction

    task automatic run_both();
        fork
            run_port(0);
            run_port(1);
        join
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack0"}, 32'(bus.ack_0), 32'd0);
        check({tag, "_ack1"}, 32'(bus.ack_1), 32'd0);
        check({tag, "_out0"}, 32'(bus.out_0), 32'd0);
        check({tag, "_out1"}, 32'(bus.out_1), 32'd0);
        check({tag, "_we"}, 32'(bus.ram_we), 32'd0);
        check({tag, "_oe"}, 32'(bus.ram_oe), 32'd0);
        check({tag, "_addr"}, 32'(bus.ram_address), 32'd0);
        check({tag, "_din"}, 32'(bus.ram_in), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        model_out[0] = '0;
        model_out[1] = '0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;

        // Contention straight out of reset: port 0 first.
        rst_n = 1'b1;
        ack_log.delete();
        ops0.push_back(mk(1'b0, 32'h100, '0, 1'b0, 0));
        ops1.push_back(mk(1'b0, 32'h101, '0, 1'b0, 0));
        run_both();
        check("reset_contention_n", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) begin
            check("reset_contention_first", 32'(ack_log[0]), 32'd0);
            check("reset_contention_second", 32'(ack_log[1]), 32'd1);
        end

        // Continuous contention: 6 writes per port, strict alternation.
        ack_log.delete();
        for (int i = 0; i < 6; i++) begin
            ops0.push_back(mk(1'b1, 32'h040 + 32'(i), 16'($urandom), 1'b0, 0));
            ops1.push_back(mk(1'b1, 32'h080 + 32'(i), 16'($urandom), 1'b0, 0));
        end
        run_both();
        check("contention_acks", 32'(ack_log.size()), 32'd12);
        for (int i = 0; i < ack_log.size(); i++)
            check($sformatf("contention_order%0d", i), 32'(ack_log[i]), 32'(i % 2));
        for (int i = 0; i < 6; i++) begin
            ops0.push_back(mk(1'b0, 32'h040 + 32'(i), '0, 1'b0, 0));
            ops1.push_back(mk(1'b0, 32'h080 + 32'(i), '0, 1'b0, 0));
        end
        run_both();

        // Write then read on port 0 alone.
        ops0.push_back(mk(1'b1, 32'h012, 16'hBEEF, 1'b1, 0));
        ops0.push_back(mk(1'b0, 32'h012, '0, 1'b1, 0));
        run_both();
        check("beef_readback", 32'(bus.out_0), 32'h0000BEEF);

        // Random mixed traffic; ports use disjoint (even/odd) addresses.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                op_t o;
                o = mk(1'($urandom_range(0, 1)),
                       32'h200 + 2 * $urandom_range(0, 31) + 32'(p),
                       16'($urandom), 1'b0, int'($urandom_range(0, 2)));
                if (p == 0) ops0.push_back(o);
                else        ops1.push_back(o);
            end
        end
        run_both();

        // Reset during the ACCESS cycle of a port 0 write.
        set_port(0, 1'b1, 1'b1, 10'h020, 16'h5555);
        @(negedge clk);
        @(negedge clk);
        check("rstw_access_we", 32'(bus.ram_we), 32'd1);
        check("rstw_access_addr", 32'(bus.ram_address), 32'h020);
        rst_n = 1'b0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        #1;
        check("rstw_we_gated", 32'(bus.ram_we), 32'd0);
        @(negedge clk);
        check_idle_outputs("rstw");
        model_out[0] = '0;
        model_out[1] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstw_after_ack0", 32'(bus.ack_0), 32'd0);
        check("rstw_after_ack1", 32'(bus.ack_1), 32'd0);
        @(posedge clk);
        #1;
        ops0.push_back(mk(1'b0, 32'h020, '0, 1'b1, 0));
        run_both();
        check("rstw_mem_unchanged", 32'(bus.out_0), 32'd0);

        // Port isolation: port 1 reads 0x3FF, port 0 idle.
        ops1.push_back(mk(1'b0, 32'h3FF, '0, 1'b1, 0));
        run_both();
        check("iso_out1", 32'(bus.out_1), 32'h00001234);
        check("iso_out0", 32'(bus.out_0), 32'd0);

        // Reset during RDATA of a port 1 read.
        set_port(1, 1'b1, 1'b0, 10'h101, '0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rstr_rdata_oe", 32'(bus.ram_oe), 32'd1);
        rst_n = 1'b0;
        set_port(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rstr_ack1", 32'(bus.ack_1), 32'd0);
        check("rstr_out1", 32'(bus.out_1), 32'd0);
        model_out[0] = '0;
        model_out[1] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstr_after_ack0", 32'(bus.ack_0), 32'd0);
        check("rstr_after_ack1", 32'(bus.ack_1), 32'd0);
        @(posedge clk);
        #1;
        ack_log.delete();
        ops0.push_back(mk(1'b0, 32'h012, '0, 1'b0, 0));
        ops1.push_back(mk(1'b0, 32'h3FF, '0, 1'b0, 0));
        run_both();
        check("rstr_contention_n", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2)
            check("rstr_contention_first", 32'(ack_log[0]), 32'd0);

        repeat (2) @(posedge clk);
        check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
